// File: rtl/ps2_kbd_rx_fifo.sv
// ps2_kbd_rx_fifo: PS/2 keyboard receiver with prefix decoding, a show-ahead
// key-event FIFO, a make-press counter that ignores typematic repeats and a
// partial-frame timeout.
//
// Handshake: the FIFO head is valid whenever code_valid=1 and stays stable
// until popped; a pop happens on a rising edge where rd_en=1 and
// code_valid=1. rd_en with code_valid=0 is ignored. The next entry appears
// the cycle after the pop.
module ps2_kbd_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic             code_valid,
  output logic [7:0]       code,
  output logic             code_ext,
  output logic             code_brk,
  output logic             overflow,
  output logic             parity_err,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]      BYTE_EXT = 8'hE0;
  localparam logic [7:0]      BYTE_BRK = 8'hF0;
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT_CYC);

  // ---------------------------------------------------------------------
  // Input synchronisers; idle PS/2 lines are high, so reset to all ones to
  // avoid a fake falling edge right after reset.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   sample_pt;
  logic                   ps2_bit;

  // Shift both PS/2 lines through the synchroniser chains.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Falling edge of the synchronised clock; data taken at the same depth as
  // the newer clock stage so it lines up with the edge.
  assign sample_pt = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign ps2_bit   = dat_sync[SYNC_STAGES-2];

  // ---------------------------------------------------------------------
  // Frame FSM. Bits are shifted in from the top so that after the stop bit
  // the start bit sits at index 0.
  // ---------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [10:0]     frame_q, frame_d;
  logic [10:0]     frame_full;
  logic [3:0]      idx_q, idx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            byte_stb;
  logic            frame_err;
  logic [7:0]      rx_byte;

  // Frame state, shift register, bit index and timeout counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic; validation happens in the stop-bit sample cycle using
  // the frame including the bit being sampled.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    to_d       = to_q;
    byte_stb   = 1'b0;
    frame_err  = 1'b0;
    frame_full = {ps2_bit, frame_q[10:1]};
    rx_byte    = frame_full[8:1];
    case (state_q)
      ST_IDLE: begin
        if (sample_pt) begin
          frame_d = {ps2_bit, 10'd0};
          idx_d   = 4'd1;
          to_d    = TO_LOAD;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (sample_pt) begin
          frame_d = frame_full;
          to_d    = TO_LOAD;
          if (idx_q == 4'd10) begin
            state_d = ST_IDLE;
            idx_d   = 4'd0;
            if (!frame_full[0] && frame_full[10] && (^frame_full[9:1]))
              byte_stb = 1'b1;
            else
              frame_err = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (to_q == '0) begin
          // Line went quiet mid-frame: drop the partial frame silently.
          state_d = ST_IDLE;
          idx_d   = 4'd0;
        end else begin
          to_d = to_q - TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Prefix decoder and key tracking. A complete event is registered into
  // push_v/push_d and written to the FIFO one cycle later.
  // ---------------------------------------------------------------------
  logic       ext_q;
  logic       brk_q;
  logic       push_v;
  logic [9:0] push_d;
  logic [8:0] held_q;
  logic [8:0] ev_key;

  assign ev_key = {ext_q, rx_byte};

  // Decode prefixes, build events, update held key and press counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_v      <= 1'b0;
      push_d      <= '0;
      held_q      <= '0;
      key_held    <= 1'b0;
      press_count <= '0;
      parity_err  <= 1'b0;
    end else begin
      push_v     <= 1'b0;
      parity_err <= frame_err;
      if (byte_stb) begin
        if (rx_byte == BYTE_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == BYTE_BRK) begin
          brk_q <= 1'b1;
        end else begin
          push_v <= 1'b1;
          push_d <= {ext_q, brk_q, rx_byte};
          ext_q  <= 1'b0;
          brk_q  <= 1'b0;
          if (!brk_q) begin
            // A make of the key already held is a typematic repeat.
            if (!(key_held && (ev_key == held_q))) begin
              press_count <= press_count + CNT_W'(1);
              held_q      <= ev_key;
              key_held    <= 1'b1;
            end
          end else if (ev_key == held_q) begin
            key_held <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead event FIFO; pointers carry one extra wrap bit.
  // ---------------------------------------------------------------------
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;
  logic [9:0]  head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = rd_en && !fifo_empty;
  assign do_push    = push_v && (!fifo_full || do_pop);

  // Pointer and sticky overflow updates; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_v && fifo_full && !do_pop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  // Event storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_d;
  end

  // Head presentation, forced to zero when empty.
  always_comb begin
    head = '0;
    if (!fifo_empty) head = mem[rd_ptr[AW-1:0]];
  end

  assign code_valid = !fifo_empty;
  assign code       = head[7:0];
  assign code_brk   = head[8];
  assign code_ext   = head[9];

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed bench for ps2_kbd_rx_fifo: bit-banged PS/2 frames, an expected
// event queue and hand-computed counter/flag values.
module tb_ps2_kbd_rx_fifo;

  localparam int FIFO_DEPTH  = 8;
  localparam int SYNC_STAGES = 3;
  localparam int TIMEOUT_CYC = 100;
  localparam int CNT_W       = 8;

  logic             clk;
  logic             resetn;
  logic             ps2_clk;
  logic             ps2_data;
  logic             rd_en;
  logic             ovf_clr;
  logic             code_valid;
  logic [7:0]       code;
  logic             code_ext;
  logic             code_brk;
  logic             overflow;
  logic             parity_err;
  logic             key_held;
  logic [CNT_W-1:0] press_count;

  int total = 0;
  int bad   = 0;
  int pe_cnt = 0;
  int pe_base;
  logic [9:0] exp_q[$];

  ps2_kbd_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .ovf_clr    (ovf_clr),
    .code_valid (code_valid),
    .code       (code),
    .code_ext   (code_ext),
    .code_brk   (code_brk),
    .overflow   (overflow),
    .parity_err (parity_err),
    .key_held   (key_held),
    .press_count(press_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with parity_err high, sampled away from the active edge.
  always @(negedge clk) if (parity_err === 1'b1) pe_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then a 10+ cycle low phase.
  // With lat=1 the code_valid latency after the falling edge is checked.
  task automatic ps2_bit(input logic b, input bit lat);
    ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    if (lat) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("lat_edge3", 32'(code_valid), 32'd0);
      @(negedge clk);
      check("lat_edge4", 32'(code_valid), 32'd1);
      repeat (8) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit lat);
    logic [10:0] f;
    f = mk_frame(b, bad_par);
    for (int i = 0; i < 11; i++) ps2_bit(f[i], lat && (i == 10));
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [10:0] f;
    f = mk_frame(b, 1'b0);
    for (int i = 0; i < n; i++) ps2_bit(f[i], 1'b0);
  endtask

  // Scoreboard pop: compare the head with the oldest expected event, then pop.
  task automatic pop_expect(input string tag);
    logic [9:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
    check({tag, "_valid"}, 32'(code_valid), 32'd1);
    check({tag, "_head"}, 32'({code_ext, code_brk, code}), 32'(e));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    rd_en = 1'b0;
    ovf_clr = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(code_valid), 32'd0);
    check({tag, "_head"}, 32'({code_ext, code_brk, code}), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_perr"}, 32'(parity_err), 32'd0);
    check({tag, "_held"}, 32'(key_held), 32'd0);
    check({tag, "_cnt"}, 32'(press_count), 32'd0);
  endtask

  initial begin
    // Reset state
    apply_reset();
    check_all_zero("reset");

    // Single make 1C with latency check
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    check("make_cnt", 32'(press_count), 32'd1);
    check("make_held", 32'(key_held), 32'd1);
    pop_expect("make");
    check("make_empty", 32'(code_valid), 32'd0);

    // Break F0 1C, then extended make E0 75
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b1, 8'h1C});
    check("brk_cnt", 32'(press_count), 32'd1);
    check("brk_held", 32'(key_held), 32'd0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    exp_q.push_back({1'b1, 1'b0, 8'h75});
    check("ext_cnt", 32'(press_count), 32'd2);
    check("ext_held", 32'(key_held), 32'd1);
    pop_expect("brk");
    pop_expect("ext");
    check("ext_empty", 32'(code_valid), 32'd0);

    // Typematic 1C x3, then 32
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h1C, 1'b0, 1'b0);
      exp_q.push_back({1'b0, 1'b0, 8'h1C});
    end
    check("typ_cnt", 32'(press_count), 32'd3);
    send_frame(8'h32, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h32});
    check("typ_new_cnt", 32'(press_count), 32'd4);
    for (int i = 0; i < 4; i++) pop_expect("typ");
    check("typ_empty", 32'(code_valid), 32'd0);

    // Parity error: single pulse, nothing queued; then 32 (repeat of held key)
    pe_base = pe_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("perr_pulses", 32'(pe_cnt - pe_base), 32'd1);
    check("perr_empty", 32'(code_valid), 32'd0);
    check("perr_cnt", 32'(press_count), 32'd4);
    send_frame(8'h32, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h32});
    check("perr_next_cnt", 32'(press_count), 32'd4);
    pop_expect("perr_next");

    // Overflow: 9 makes into an 8-deep FIFO from a fresh reset
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      send_frame(8'h15 + 8'(i), 1'b0, 1'b0);
      if (i < FIFO_DEPTH) exp_q.push_back({2'b00, 8'h15 + 8'(i)});
    end
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(press_count), 32'd9);
    repeat (5) @(negedge clk);
    check("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_expect("ovf_data");
    check("ovf_empty", 32'(code_valid), 32'd0);

    // Timeout: 5 bits then idle line; next frame must decode cleanly
    pe_base = pe_cnt;
    send_bits(8'h1C, 5);
    repeat (TIMEOUT_CYC + 5) @(negedge clk);
    check("to_empty", 32'(code_valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    check("to_perr", 32'(pe_cnt - pe_base), 32'd0);
    check("to_cnt", 32'(press_count), 32'd10);
    pop_expect("to_data");
    check("to_after", 32'(code_valid), 32'd0);

    // Reset mid-frame with an event queued
    send_frame(8'h33, 1'b0, 1'b0);
    check("rst_pre_valid", 32'(code_valid), 32'd1);
    send_bits(8'h1C, 4);
    apply_reset();
    check_all_zero("rst_mid");
    send_frame(8'h1C, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    check("rst_post_cnt", 32'(press_count), 32'd1);
    pop_expect("rst_post");
    check("rst_post_empty", 32'(code_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
